avst_rr_arbiter: RTL and testbench
==================================

Name: avst_rr_arbiter

Overview:
- Round-robin arbiter that shares one Avalon-ST output stream among NUM_IN Avalon-ST requesters.
- Built around a single registered output stage, so out_* are flop outputs and ready is combinational back to the winner only.
- Sits in front of the shared sort-engine input or any shared downstream stage.
- Optional packet lock keeps the grant until end-of-packet.

Parameters:
- NUM_IN, 4, number of requesters (>=2)
- DWIDTH, 8, data width per requester
- SRC_W, $clog2(NUM_IN), source index width (derived, localparam)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- in_data_i  in  NUM_IN*DWIDTH  flattened requester data, requester k at bits [k*DWIDTH +: DWIDTH]
- in_eop_i  in  NUM_IN  end-of-packet per requester
- in_valid_i  in  NUM_IN  valid per requester
- in_ready_o  out  NUM_IN  ready per requester (one-hot or zero)
- out_data_o  out  DWIDTH  selected data
- out_eop_o  out  1  selected eop
- out_src_o  out  SRC_W  index of requester that produced the beat
- out_valid_o  out  1  output valid
- out_ready_i  in  1  downstream ready

Behaviour:
- Reset values: out_data_o=0, out_eop_o=0, out_src_o=0, out_valid_o=0, rr pointer ptr=0, state=ARB.
- Stage enable: stg_en = !out_valid_o || out_ready_i. A full output stage refills in the same cycle it drains.
- Grant:
  - Combinational rotate-priority search of in_valid_i starting at index ptr, wrapping NUM_IN-1 -> 0.
  - gnt is one-hot or zero.
- Handshake:
  - in_ready_o = gnt & {NUM_IN{stg_en}}. Non-granted requesters always see ready=0.
  - Requesters must hold data/valid stable until accepted.
- Load on stg_en:
  - If gnt != 0: out_data_o/out_eop_o/out_src_o <= granted requester's values; out_valid_o <= 1.
  - Else: out_valid_o <= 0 and data registers hold.
- Latency: 1 cycle from acceptance to out_valid_o.
- Throughput: 1 beat/cycle while out_ready_i=1.
- Pointer: on each accepted beat from k (per-beat mode), ptr <= (k+1) mod NUM_IN. NUM_IN not a power of two must wrap correctly, e.g. NUM_IN=3: 2 -> 0.
- Fairness: every continuously-valid requester is granted within NUM_IN accepted beats.
- Backpressure: out_ready_i=0 with out_valid_o=1 -> all in_ready_o=0; ptr and state frozen.
- Simultaneous requests: all valid -> winner is the first valid index at or after ptr.
- No requests: output stage empties after drain; ptr unchanged.
- Reset mid-transfer: everything returns to reset values immediately. Any beat in the output register is dropped.

Optional Feature:
- Macro: AVST_ARB_PKT_LOCK_EN
- Defined: 2-state FSM ARB/LOCK with lock register lk_idx.
  - ARB: rr grant as above. Accepting a beat with eop=0 from k -> LOCK, lk_idx<=k; ptr not advanced. Accepting with eop=1 -> stay ARB, ptr<=k+1.
  - LOCK: gnt is exclusively lk_idx and only when in_valid_i[lk_idx]=1. Other requesters get no grant even when the locked one is idle. Accepting the eop=1 beat from lk_idx -> ARB, ptr<=lk_idx+1.
  - Reset -> ARB.
- Undefined: no FSM. in_eop_i is passed through to out_eop_o only, and arbitration is per beat.

Decomposition:
- Package avst_arb_pkg: state enum arb_state_t {ARB, LOCK}; function rr_next(idx, n) returning (idx+1) mod n.
- Sub-module rr_grant_sel: purely combinational. Inputs are the request vector and ptr; outputs are a one-hot grant and the binary index. It is reused by future multi-port controllers.

Test Plan:
- All 4 valid, out_ready_i=1, per-beat mode -> out_src_o sequence 0,1,2,3,0,1; each in_ready_o pulses once per 4 cycles.
- Only req2 valid with data 0xA5 -> out_data_o=0xA5, out_src_o=2 one cycle after acceptance; in_ready_o=4'b0100.
- out_ready_i=0 for 5 cycles while out_valid_o=1 -> out_* stable, in_ready_o=0, ptr unchanged. Release -> next grant continues from the saved ptr.
- NUM_IN=3, all valid -> out_src_o cycles 0,1,2,0, exercising the non-power-of-two wrap.
- AVST_ARB_PKT_LOCK_EN: req1 sends 3-beat packet (eop on beat 3) while req0 and req2 are valid. Expected: out_src_o=1,1,1 then 2,0. Insert a req1 valid gap mid-packet -> no other source is granted during the gap.
- Assert rst_i while out_valid_o=1 and in LOCK -> out_valid_o=0 immediately, state ARB, ptr 0. The first post-reset grant goes to the lowest valid index.

Source files
------------

// File: rtl/avst_arb_pkg.sv
// avst_arb_pkg: shared state type and pointer helper for the
// Avalon-ST round-robin arbiter (lock FSM under AVST_ARB_PKT_LOCK_EN).
package avst_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  function automatic int unsigned rr_next(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_grant_sel.sv
// rr_grant_sel: combinational rotate-priority search starting at i_ptr.
// Produces a one-hot (or zero) grant plus the winner's binary index.
module rr_grant_sel #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx
);

  localparam int unsigned NU = N;

  logic [W-1:0] w_k;

  function automatic int unsigned wrap(
    input int unsigned p,
    input int unsigned o
  );
    int unsigned s;
    s = p + o;
    return (s >= NU) ? s - NU : s;
  endfunction

  // Scan farthest-to-nearest so the slot closest to i_ptr wins last.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_k   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_k = W'(wrap(32'(i_ptr), 32'(i)));
      if (i_req[w_k]) begin
        o_gnt      = '0;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end

endmodule

// File: rtl/avst_rr_arbiter.sv
// avst_rr_arbiter: NUM_IN-to-1 Avalon-ST round-robin arbiter, registered out.
// Define AVST_ARB_PKT_LOCK_EN to hold the grant until end-of-packet.
module avst_rr_arbiter
  import avst_arb_pkg::*;
#(
  parameter  int NUM_IN = 4,
  parameter  int DWIDTH = 8,
  localparam int SRC_W  = $clog2(NUM_IN)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_IN*DWIDTH-1:0] in_data_i,
  input  logic [NUM_IN-1:0]        in_eop_i,
  input  logic [NUM_IN-1:0]        in_valid_i,
  output logic [NUM_IN-1:0]        in_ready_o,
  output logic [DWIDTH-1:0]        out_data_o,
  output logic                     out_eop_o,
  output logic [SRC_W-1:0]         out_src_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i
);

  logic [SRC_W-1:0]  r_ptr;
  logic [NUM_IN-1:0] w_req;
  logic [NUM_IN-1:0] w_gnt;
  logic [SRC_W-1:0]  w_idx;
  logic              w_stg_en;
  logic              w_acc;
  logic              w_ptr_adv;
  logic [DWIDTH-1:0] w_sel_data;
  logic              w_sel_eop;

  assign w_stg_en = !out_valid_o || out_ready_i;

`ifdef AVST_ARB_PKT_LOCK_EN
  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [SRC_W-1:0]  r_lk_idx;
  logic [NUM_IN-1:0] w_lk_mask;
  logic              w_lk_load;

  always_comb begin
    w_lk_mask           = '0;
    w_lk_mask[r_lk_idx] = 1'b1;
  end

  // While locked only the owner may request, even if it is idle.
  assign w_req = (r_state == LOCK) ?
                 (in_valid_i & w_lk_mask) : in_valid_i;
`else
  assign w_req = in_valid_i;
`endif

  rr_grant_sel #(
    .N (NUM_IN),
    .W (SRC_W)
  ) u_sel (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign in_ready_o = w_gnt & {NUM_IN{w_stg_en}};
  assign w_acc      = w_stg_en && (|w_gnt);

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (w_gnt[k]) w_sel_data = in_data_i[k*DWIDTH +: DWIDTH];
    end
  end

  assign w_sel_eop = |(w_gnt & in_eop_i);

`ifdef AVST_ARB_PKT_LOCK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ARB;
      r_lk_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_lk_load) r_lk_idx <= w_idx;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_adv   = 1'b0;
    w_lk_load   = 1'b0;
    unique case (r_state)
      ARB: begin
        if (w_acc) begin
          if (w_sel_eop) begin
            w_ptr_adv = 1'b1;
          end else begin
            w_state_nxt = LOCK;
            w_lk_load   = 1'b1;
          end
        end
      end
      LOCK: begin
        if (w_acc && w_sel_eop) begin
          w_state_nxt = ARB;
          w_ptr_adv   = 1'b1;
        end
      end
    endcase
  end
`else
  assign w_ptr_adv = w_acc;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_ptr_adv) begin
      r_ptr <= SRC_W'(rr_next(32'(w_idx), NUM_IN));
    end
  end

  // Data/eop/src hold when the stage empties; only valid drops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data_o  <= '0;
      out_eop_o   <= 1'b0;
      out_src_o   <= '0;
      out_valid_o <= 1'b0;
    end else if (w_stg_en) begin
      out_valid_o <= |w_gnt;
      if (|w_gnt) begin
        out_data_o <= w_sel_data;
        out_eop_o  <= w_sel_eop;
        out_src_o  <= w_idx;
      end
    end
  end

endmodule

// File: tb/tb_avst_rr_arbiter.sv
// tb_avst_rr_arbiter: directed checks of the round-robin arbiter,
// a NUM_IN=3 wrap instance and, when enabled, packet lock.
module tb_avst_rr_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;

  logic [31:0] d;
  logic [3:0]  eop;
  logic [3:0]  vld;
  logic [3:0]  rdy;
  logic [7:0]  od;
  logic        oeop;
  logic [1:0]  osrc;
  logic        ov;
  logic        ordy;

  logic [23:0] d3;
  logic [2:0]  eop3;
  logic [2:0]  vld3;
  logic [2:0]  rdy3;
  logic [7:0]  od3;
  logic        oeop3;
  logic [1:0]  osrc3;
  logic        ov3;
  logic        ordy3;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  avst_rr_arbiter #(.NUM_IN(4), .DWIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (d),
    .in_eop_i    (eop),
    .in_valid_i  (vld),
    .in_ready_o  (rdy),
    .out_data_o  (od),
    .out_eop_o   (oeop),
    .out_src_o   (osrc),
    .out_valid_o (ov),
    .out_ready_i (ordy)
  );

  avst_rr_arbiter #(.NUM_IN(3), .DWIDTH(8)) dut3 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (d3),
    .in_eop_i    (eop3),
    .in_valid_i  (vld3),
    .in_ready_o  (rdy3),
    .out_data_o  (od3),
    .out_eop_o   (oeop3),
    .out_src_o   (osrc3),
    .out_valid_o (ov3),
    .out_ready_i (ordy3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_d(input int k, input logic [7:0] v);
    d[k*8 +: 8] = v;
  endtask

  initial begin
    rst_i = 1'b1;
    d     = '0;
    eop   = '0;
    vld   = '0;
    ordy  = 1'b1;
    d3    = '0;
    eop3  = '0;
    vld3  = '0;
    ordy3 = 1'b1;
    repeat (2) tick();
    chk("rst_valid", ov, 0);
    chk("rst_data", od, 0);
    chk("rst_src", osrc, 0);
    chk("rst_eop", oeop, 0);
    chk("rst_valid3", ov3, 0);
    rst_i = 1'b0;
    tick();

    // all four valid: 0,1,2,3,0,1
    for (int k = 0; k < 4; k++) set_d(k, 8'h10 + 8'(k));
    eop = 4'hF;
    vld = 4'hF;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("rr_rdy", rdy, 32'(1) << (i % 4));
      tick();
      chk("rr_src", osrc, i % 4);
      chk("rr_data", od, 8'h10 + (i % 4));
      chk("rr_vld", ov, 1);
    end

    // only req2, ptr now 2
    vld = 4'b0100;
    set_d(2, 8'hA5);
    #1;
    chk("one_rdy", rdy, 4'b0100);
    tick();
    chk("one_data", od, 8'hA5);
    chk("one_src", osrc, 2);
    chk("one_vld", ov, 1);

    // backpressure for 5 cycles, ptr stays 3
    ordy = 1'b0;
    vld  = 4'hF;
    set_d(2, 8'h12);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rdy", rdy, 0);
      chk("bp_data", od, 8'hA5);
      chk("bp_src", osrc, 2);
      chk("bp_vld", ov, 1);
      tick();
    end
    ordy = 1'b1;
    #1;
    chk("bp_rel_rdy", rdy, 4'b1000);
    tick();
    chk("bp_rel_src", osrc, 3);
    chk("bp_rel_data", od, 8'h13);

    // drain with no requests, ptr stays 0
    vld = '0;
    tick();
    chk("drain_vld", ov, 0);
    chk("drain_hold", od, 8'h13);
    tick();
    chk("idle_vld", ov, 0);
    vld = 4'b0110;
    #1;
    chk("idle_rdy", rdy, 4'b0010);
    tick();
    chk("idle_src", osrc, 1);
    vld = '0;
    tick();

    // NUM_IN=3 wrap 0,1,2,0
    d3   = {8'h22, 8'h21, 8'h20};
    eop3 = 3'b111;
    vld3 = 3'b111;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("n3_rdy", rdy3, 32'(1) << (i % 3));
      tick();
      chk("n3_src", osrc3, i % 3);
      chk("n3_data", od3, 8'h20 + (i % 3));
    end
    vld3 = '0;
    tick();

`ifdef AVST_ARB_PKT_LOCK_EN
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    vld = 4'b0001;
    eop = 4'hF;
    #1;
    tick();
    // req1 3-beat packet, ptr is 1
    vld = 4'b0111;
    eop = 4'b0101;
    set_d(1, 8'hB1);
    #1;
    chk("lk_b1_rdy", rdy, 4'b0010);
    tick();
    chk("lk_b1_src", osrc, 1);
    chk("lk_b1_data", od, 8'hB1);
    vld = 4'b0101;
    #1;
    chk("lk_gap_rdy", rdy, 0);
    tick();
    chk("lk_gap_vld", ov, 0);
    chk("lk_gap_rdy2", rdy, 0);
    tick();
    vld = 4'b0111;
    set_d(1, 8'hB2);
    #1;
    chk("lk_b2_rdy", rdy, 4'b0010);
    tick();
    chk("lk_b2_src", osrc, 1);
    chk("lk_b2_data", od, 8'hB2);
    eop = 4'b0111;
    set_d(1, 8'hB3);
    #1;
    tick();
    chk("lk_b3_src", osrc, 1);
    chk("lk_b3_eop", oeop, 1);
    vld = 4'b0101;
    tick();
    chk("lk_next_src", osrc, 2);
    tick();
    chk("lk_wrap_src", osrc, 0);
    vld = '0;
    tick();
`endif

    // reset while holding a beat (and locked when enabled)
    vld = 4'b0010;
    eop = 4'b0000;
    set_d(1, 8'hC1);
    tick();
    ordy = 1'b0;
    vld  = '0;
    #1;
    chk("mr_pre_vld", ov, 1);
    rst_i = 1'b1;
    #1;
    chk("mr_vld", ov, 0);
    chk("mr_data", od, 0);
    chk("mr_src", osrc, 0);
    tick();
    rst_i = 1'b0;
    ordy  = 1'b1;
    vld   = 4'b1001;
    eop   = 4'hF;
    #1;
    chk("mr_rdy", rdy, 4'b0001);
    tick();
    chk("mr_src1", osrc, 0);
    chk("mr_vld1", ov, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
